// File: rtl/rv_load_store_unit_pkg.sv
// Shared types for the RISC-V load/store unit.
// Access sizes, FSM states and captured request control.
package rv_load_store_unit_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    BEAT0,
    WAIT0,
    BEAT1,
    WAIT1,
    RESP
  } state_e;

  typedef struct packed {
    logic  we;
    size_e size;
    logic  uns;
  } req_ctl_t;

  function automatic logic [3:0] size_bytes(size_e s);
    return 4'd1 << s;
  endfunction

endpackage

// File: rtl/rv_load_store_unit_if.sv
// Core request/response and bus beat signals of the LSU.
// slave is the LSU view, master the core-plus-memory view.
interface rv_load_store_unit_if #(
  parameter int XLEN = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_error;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [XLEN-1:0]   mem_addr;
  logic              mem_we;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rsp_valid;
  logic [XLEN-1:0]   mem_rsp_rdata;

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_error,
    input  rsp_ready,
    output mem_req_valid, mem_addr, mem_we,
    output mem_be, mem_wdata,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_rdata
  );

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_error,
    output rsp_ready,
    input  mem_req_valid, mem_addr, mem_we,
    input  mem_be, mem_wdata,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_rdata
  );

endinterface

// File: rtl/rv_lsu_align.sv
// Lane shifter for the LSU: positions store bytes/enables for
// both beats and assembles/extends load data from two beats.
module rv_lsu_align
  import rv_load_store_unit_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OW = $clog2(NB)
) (
  input  size_e           size,
  input  logic [OW-1:0]   offset,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] hi,
  output logic [NB-1:0]   be0,
  output logic [NB-1:0]   be1,
  output logic [XLEN-1:0] wd0,
  output logic [XLEN-1:0] wd1,
  output logic [XLEN-1:0] ldata
);

  logic [OW+2:0]     sh;
  logic [3:0]        nbytes;
  logic [NB-1:0]     smask;
  logic [XLEN-1:0]   dmask;
  logic [2*NB-1:0]   be_w;
  logic [2*XLEN-1:0] wd_w;
  logic [XLEN-1:0]   raw;

  assign sh     = {offset, 3'b000};
  assign nbytes = size_bytes(size);

  // Byte and bit masks covering the access size.
  always_comb begin
    smask = '0;
    dmask = '0;
    for (int i = 0; i < NB; i++) begin
      smask[i]       = (i < int'(nbytes));
      dmask[8*i +: 8] = {8{smask[i]}};
    end
  end

  // Double-width shift: low half is beat 0, high half beat 1.
  assign be_w = {{NB{1'b0}}, smask} << offset;
  assign wd_w = {{XLEN{1'b0}}, wdata & dmask} << sh;
  assign be0  = be_w[NB-1:0];
  assign be1  = be_w[2*NB-1:NB];
  assign wd0  = wd_w[XLEN-1:0];
  assign wd1  = wd_w[2*XLEN-1:XLEN];

  assign raw = XLEN'({hi, lo} >> sh);

  // Truncate to size, then sign- or zero-extend.
  always_comb begin
    ldata = raw;
    unique case (size)
      SIZE_B:
        ldata = is_unsigned ? XLEN'(raw[7:0])
                            : XLEN'($signed(raw[7:0]));
      SIZE_H:
        ldata = is_unsigned ? XLEN'(raw[15:0])
                            : XLEN'($signed(raw[15:0]));
      SIZE_W:
        ldata = is_unsigned ? XLEN'(raw[31:0])
                            : XLEN'($signed(raw[31:0]));
      SIZE_D:
        ldata = raw;
      default:
        ldata = raw;
    endcase
  end

endmodule

// File: rtl/rv_load_store_unit.sv
// RISC-V load/store unit: one request at a time, up to two
// aligned bus beats per access, sign/zero-extended load result.
module rv_load_store_unit
  import rv_load_store_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit SPLIT_MISALIGNED = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  rv_load_store_unit_if.slave bus
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  state_e          state_q;
  state_e          state_d;
  req_ctl_t        ctl_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata0_q;
  logic [XLEN-1:0] rsp_rdata_q;
  logic            rsp_error_q;

  logic            idle;
  logic            beat;
  logic            hi_beat;
  logic            resp;

  size_e           in_size;
  logic [4:0]      in_off;
  logic [4:0]      in_nb;
  logic            in_illegal;
  logic            in_mis;
  logic            in_err;

  logic [OW-1:0]   off_q;
  logic            split;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] ld_lo;
  logic [XLEN-1:0] ldata;
  logic [XLEN-1:0] ld_res;
  logic [NB-1:0]   be0;
  logic [NB-1:0]   be1;
  logic [XLEN-1:0] wd0;
  logic [XLEN-1:0] wd1;

  logic            acc;
  logic            fin0;
  logic            fin1;

  // Incoming request classification.
  assign in_size    = size_e'(bus.req_size);
  assign in_off     = 5'(bus.req_addr[OW-1:0]);
  assign in_nb      = 5'(size_bytes(in_size));
  assign in_illegal = (XLEN == 32) && (in_size == SIZE_D);
  assign in_mis     = |(in_off & (in_nb - 5'd1));
  assign in_err     = in_illegal ||
                      (in_mis && !SPLIT_MISALIGNED);

  // Captured access: second beat needed when it crosses a word.
  assign off_q = addr_q[OW-1:0];
  assign split = SPLIT_MISALIGNED &&
                 ((5'(off_q) + 5'(size_bytes(ctl_q.size)))
                  > 5'(NB));

  assign base  = {addr_q[XLEN-1:OW], {OW{1'b0}}};
  assign ld_lo = (state_q == WAIT1) ? rdata0_q
                                    : bus.mem_rsp_rdata;

  rv_lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .size       (ctl_q.size),
    .offset     (off_q),
    .is_unsigned(ctl_q.uns),
    .wdata      (wdata_q),
    .lo         (ld_lo),
    .hi         (bus.mem_rsp_rdata),
    .be0        (be0),
    .be1        (be1),
    .wd0        (wd0),
    .wd1        (wd1),
    .ldata      (ldata)
  );

  assign ld_res = ctl_q.we ? '0 : ldata;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and state-decoded strobes.
  always_comb begin
    state_d = state_q;
    idle    = 1'b0;
    beat    = 1'b0;
    hi_beat = 1'b0;
    resp    = 1'b0;
    unique case (state_q)
      IDLE: begin
        idle = 1'b1;
        if (bus.req_valid)
          state_d = in_err ? RESP : BEAT0;
      end
      BEAT0: begin
        beat = 1'b1;
        if (bus.mem_req_ready) state_d = WAIT0;
      end
      WAIT0: begin
        if (bus.mem_rsp_valid)
          state_d = split ? BEAT1 : RESP;
      end
      BEAT1: begin
        beat    = 1'b1;
        hi_beat = 1'b1;
        if (bus.mem_req_ready) state_d = WAIT1;
      end
      WAIT1: begin
        if (bus.mem_rsp_valid) state_d = RESP;
      end
      RESP: begin
        resp = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc  = idle && bus.req_valid;
  assign fin0 = (state_q == WAIT0) && bus.mem_rsp_valid;
  assign fin1 = (state_q == WAIT1) && bus.mem_rsp_valid;

  // Request capture and response data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      unique case (1'b1)
        acc: begin
          ctl_q.we    <= bus.req_we;
          ctl_q.size  <= in_size;
          ctl_q.uns   <= bus.req_unsigned;
          addr_q      <= bus.req_addr;
          wdata_q     <= bus.req_wdata;
          rsp_error_q <= in_err;
          rsp_rdata_q <= '0;
        end
        fin0: begin
          rdata0_q <= bus.mem_rsp_rdata;
          if (!split) rsp_rdata_q <= ld_res;
        end
        fin1: begin
          rsp_rdata_q <= ld_res;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready     = idle;
  assign bus.rsp_valid     = resp;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_error     = rsp_error_q;
  assign bus.mem_req_valid = beat;
  assign bus.mem_we        = ctl_q.we;
  assign bus.mem_addr      = hi_beat ? base + XLEN'(NB)
                                     : base;
  assign bus.mem_be        = !beat   ? '0
                           : hi_beat ? be1 : be0;
  assign bus.mem_wdata     = hi_beat ? wd1 : wd0;

endmodule

// File: tb/tb_rv_load_store_unit.sv
// Scoreboard bench for rv_load_store_unit, XLEN=32.
// dut0 rejects misaligned accesses, dut1 splits them.
module tb_rv_load_store_unit;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    bit          hold;
  } beat_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int acc_cyc = 0;
  int mem_stall = 0;
  int rsp_stall = 0;
  bit rsp_seen = 0;

  beat_t mem_q[$];
  rsp_t  rsp_q[$];

  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;

  rv_load_store_unit_if #(.XLEN(32)) if0 ();
  rv_load_store_unit_if #(.XLEN(32)) if1 ();

  rv_load_store_unit #(
    .XLEN(32), .SPLIT_MISALIGNED(1'b0)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

  rv_load_store_unit #(
    .XLEN(32), .SPLIT_MISALIGNED(1'b1)
  ) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  assign if0.req_valid     = req_valid & ~sel;
  assign if1.req_valid     = req_valid & sel;
  assign if0.req_we        = req_we;
  assign if1.req_we        = req_we;
  assign if0.req_size      = req_size;
  assign if1.req_size      = req_size;
  assign if0.req_unsigned  = req_unsigned;
  assign if1.req_unsigned  = req_unsigned;
  assign if0.req_addr      = req_addr;
  assign if1.req_addr      = req_addr;
  assign if0.req_wdata     = req_wdata;
  assign if1.req_wdata     = req_wdata;
  assign if0.rsp_ready     = rsp_ready;
  assign if1.rsp_ready     = rsp_ready;
  assign if0.mem_req_ready = mem_req_ready;
  assign if1.mem_req_ready = mem_req_ready;
  assign if0.mem_rsp_valid = mem_rsp_valid;
  assign if1.mem_rsp_valid = mem_rsp_valid;
  assign if0.mem_rsp_rdata = mem_rsp_rdata;
  assign if1.mem_rsp_rdata = mem_rsp_rdata;

  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_error;
  logic        o_mem_req_valid;
  logic [31:0] o_mem_addr;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;

  assign o_req_ready = sel ? if1.req_ready : if0.req_ready;
  assign o_rsp_valid = sel ? if1.rsp_valid : if0.rsp_valid;
  assign o_rsp_rdata = sel ? if1.rsp_rdata : if0.rsp_rdata;
  assign o_rsp_error = sel ? if1.rsp_error : if0.rsp_error;
  assign o_mem_req_valid =
    sel ? if1.mem_req_valid : if0.mem_req_valid;
  assign o_mem_addr  = sel ? if1.mem_addr : if0.mem_addr;
  assign o_mem_we    = sel ? if1.mem_we : if0.mem_we;
  assign o_mem_be    = sel ? if1.mem_be : if0.mem_be;
  assign o_mem_wdata = sel ? if1.mem_wdata : if0.mem_wdata;

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  // Memory side: checks each beat, stalls, returns read data.
  initial begin : bus_agent
    beat_t b;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && o_mem_req_valid) begin
        if (mem_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexp: got addr %h want none",
                   o_mem_addr);
        end else begin
          chk("mem_addr", o_mem_addr, mem_q[0].addr);
          chk("mem_be", o_mem_be, mem_q[0].be);
          chk("mem_wdata", o_mem_wdata, mem_q[0].wdata);
          chk("mem_we", o_mem_we, mem_q[0].we);
          if (mem_stall > 0) begin
            mem_req_ready = 1'b0;
            mem_stall--;
          end else begin
            mem_req_ready = 1'b1;
            b = mem_q.pop_front();
            @(posedge clk);
            #1;
            if (!b.hold) begin
              mem_rsp_valid = 1'b1;
              mem_rsp_rdata = b.rdata;
              @(posedge clk);
              #1;
              mem_rsp_valid = 1'b0;
              mem_rsp_rdata = '0;
            end
          end
        end
      end else begin
        mem_req_ready = 1'b1;
      end
    end
  end

  // Core response monitor: pops the scoreboard on handshake.
  initial begin : rsp_mon
    rsp_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rsp_ready = 1'b1;
        rsp_seen  = 1'b0;
      end else if (o_rsp_valid) begin
        if (rsp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rsp_unexp: got rsp_valid 1 want 0");
        end else begin
          if (!rsp_seen) begin
            rsp_seen = 1'b1;
            if (rsp_q[0].lat >= 0)
              chk("rsp_lat", 64'(cyc - acc_cyc),
                  64'(rsp_q[0].lat));
          end
          chk("rsp_rdata", o_rsp_rdata, rsp_q[0].rdata);
          chk("rsp_error", o_rsp_error, rsp_q[0].err);
          if (rsp_stall > 0) begin
            rsp_ready = 1'b0;
            rsp_stall--;
          end else begin
            rsp_ready = 1'b1;
            void'(rsp_q.pop_front());
            rsp_seen = 1'b0;
          end
        end
      end else begin
        rsp_ready = 1'b1;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(rsp_q.size() == 0 && mem_q.size() == 0 &&
             o_req_ready) && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got pending %0d/%0d want 0/0",
               rsp_q.size(), mem_q.size());
      rsp_q.delete();
      mem_q.delete();
    end
  endtask

  task automatic start(input logic s, input int ms,
                       input int rs);
    wait_idle();
    sel       = s;
    mem_stall = ms;
    rsp_stall = rs;
  endtask

  task automatic beat(input logic [31:0] a,
                      input logic [3:0] be,
                      input logic [31:0] wd, input logic we,
                      input logic [31:0] rd, input bit hold);
    beat_t b;
    b = '{a, be, wd, we, rd, hold};
    mem_q.push_back(b);
  endtask

  task automatic expect_rsp(input logic [31:0] rd,
                            input logic err, input int lat);
    rsp_t r;
    r = '{rd, err, lat};
    rsp_q.push_back(r);
  endtask

  task automatic issue(input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a,
                       input logic [31:0] wd);
    int n = 0;
    @(posedge clk);
    #1;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    @(negedge clk);
    while (!o_req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!o_req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got req_ready 0 want 1");
    end
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", o_rsp_valid, 0);
    chk("rst_mem_req_valid", o_mem_req_valid, 0);
    chk("rst_mem_be", o_mem_be, 0);
    chk("rst_rsp_rdata", o_rsp_rdata, 0);
    chk("rst_rsp_error", o_rsp_error, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", o_req_ready, 1);

    // LW aligned, minimum latency
    start(0, 0, 0);
    beat(32'h100, 4'b1111, 0, 0, 32'hDEADBEEF, 0);
    expect_rsp(32'hDEADBEEF, 0, 3);
    issue(0, 2'b10, 0, 32'h100, 0);

    // LB / LBU from the top lane
    start(0, 0, 0);
    beat(32'h100, 4'b1000, 0, 0, 32'h80123456, 0);
    expect_rsp(32'hFFFFFF80, 0, 3);
    issue(0, 2'b00, 0, 32'h103, 0);
    start(0, 0, 0);
    beat(32'h100, 4'b1000, 0, 0, 32'h80123456, 0);
    expect_rsp(32'h00000080, 0, 3);
    issue(0, 2'b00, 1, 32'h103, 0);

    // SH to the upper half
    start(0, 0, 0);
    beat(32'h100, 4'b1100, 32'h12340000, 1, 0, 0);
    expect_rsp(0, 0, 3);
    issue(1, 2'b01, 0, 32'h102, 32'h00001234);

    // Rejected misaligned store and illegal size
    start(0, 0, 0);
    expect_rsp(0, 1, 1);
    issue(1, 2'b10, 0, 32'h101, 32'h12345678);
    start(0, 0, 0);
    expect_rsp(0, 1, 1);
    issue(0, 2'b11, 0, 32'h100, 0);
    start(1, 0, 0);
    expect_rsp(0, 1, 1);
    issue(0, 2'b11, 0, 32'h100, 0);

    // Split LW across two words
    start(1, 0, 0);
    beat(32'h100, 4'b1000, 0, 0, 32'h11AABBCC, 0);
    beat(32'h104, 4'b0111, 0, 0, 32'hFF332244, 0);
    expect_rsp(32'h33224411, 0, 5);
    issue(0, 2'b10, 0, 32'h103, 0);

    // Split SW
    start(1, 0, 0);
    beat(32'h104, 4'b1100, 32'hC3D40000, 1, 0, 0);
    beat(32'h108, 4'b0011, 32'h0000A1B2, 1, 0, 0);
    expect_rsp(0, 0, 5);
    issue(1, 2'b10, 0, 32'h106, 32'hA1B2C3D4);

    // Misaligned half inside one word
    start(1, 0, 0);
    beat(32'h100, 4'b0110, 0, 0, 32'h00ABCD00, 0);
    expect_rsp(32'h0000ABCD, 0, 3);
    issue(0, 2'b01, 1, 32'h101, 0);
    start(1, 0, 0);
    beat(32'h100, 4'b0110, 0, 0, 32'h00ABCD00, 0);
    expect_rsp(32'hFFFFABCD, 0, 3);
    issue(0, 2'b01, 0, 32'h101, 0);

    // Second beat wraps to address 0
    start(1, 0, 0);
    beat(32'hFFFFFFFC, 4'b1100, 0, 0, 32'h55661234, 0);
    beat(32'h00000000, 4'b0011, 0, 0, 32'hABCD7788, 0);
    expect_rsp(32'h77885566, 0, 5);
    issue(0, 2'b10, 0, 32'hFFFFFFFE, 0);

    // Bus stall then response stall
    start(0, 5, 0);
    beat(32'h200, 4'b1111, 0, 0, 32'h0BADF00D, 0);
    expect_rsp(32'h0BADF00D, 0, 8);
    issue(0, 2'b10, 0, 32'h200, 0);
    start(0, 0, 3);
    beat(32'h200, 4'b1100, 0, 0, 32'hCAFE0000, 0);
    expect_rsp(32'h0000CAFE, 0, 3);
    issue(0, 2'b01, 1, 32'h202, 0);

    // Reset while waiting for the bus response
    start(0, 0, 0);
    beat(32'h300, 4'b1111, 0, 0, 0, 1);
    issue(0, 2'b10, 0, 32'h300, 0);
    for (int n = 0; n < 50 && mem_q.size() != 0; n++)
      @(negedge clk);
    chk("abort_beat_taken", mem_q.size(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", o_rsp_valid, 0);
    chk("abort_mem_req_valid", o_mem_req_valid, 0);
    chk("abort_mem_be", o_mem_be, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", o_req_ready, 1);

    // Stray bus response while idle
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    repeat (3) @(negedge clk);
    chk("stray_rsp_valid", o_rsp_valid, 0);
    chk("stray_req_ready", o_req_ready, 1);

    // Normal access after reset
    start(1, 0, 0);
    beat(32'h300, 4'b0001, 0, 0, 32'h0000007F, 0);
    expect_rsp(32'h0000007F, 0, 3);
    issue(0, 2'b00, 0, 32'h300, 0);

    wait_idle();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_load_store_unit.md
RV_LOAD_STORE_UNIT -- requirements
Module: rv_load_store_unit

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values 32 or 64.
REQ-002 Parameter SPLIT_MISALIGNED, default 0; 1 = split misaligned access into two bus beats, 0 = reject it with an error.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid / req_ready  in / out  1 / 1  core request handshake.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 half, 10 word, 11 double.
REQ-008 req_unsigned  in  1  zero-extend load result when 1.
REQ-009 req_addr / req_wdata  in  XLEN / XLEN  byte address; store data, right-aligned.
REQ-010 rsp_valid / rsp_ready  out / in  1 / 1  core response handshake.
REQ-011 rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
REQ-012 rsp_error  out  1  misaligned (SPLIT_MISALIGNED=0) or illegal size.
REQ-013 mem_req_valid / mem_req_ready  out / in  1 / 1  bus request handshake.
REQ-014 mem_addr / mem_we  out  XLEN / 1  beat address, aligned to XLEN/8; write enable.
REQ-015 mem_be / mem_wdata  out  XLEN/8 / XLEN  byte lanes; lane-positioned store data.
REQ-016 mem_rsp_valid / mem_rsp_rdata  in  1 / XLEN  beat completion (loads and stores), read data.

Function
REQ-017 FSM states: IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP.
REQ-018 req_ready = 1 only in IDLE; transfer on req_valid & req_ready; all request fields captured into registers.
REQ-019 Size bytes = 1 << req_size; offset = addr mod XLEN/8; misaligned = offset not a multiple of size bytes; crosses = offset + size bytes > XLEN/8.
REQ-020 Illegal size (11 when XLEN=32), or misaligned with SPLIT_MISALIGNED=0: IDLE -> RESP directly, no bus beat, rsp_error=1.
REQ-021 Otherwise IDLE -> BEAT0; mem_req_valid=1 in BEAT0/BEAT1, fields stable until mem_req_ready; then -> WAIT0/WAIT1.
REQ-022 Beat 0: mem_addr = addr with offset bits cleared; mem_be = size mask << offset, truncated to XLEN/8 lanes; mem_wdata = wdata << 8*offset.
REQ-023 WAIT0 on mem_rsp_valid: -> BEAT1 if crosses (SPLIT_MISALIGNED=1 only), else -> RESP; load bytes of beat 0 captured.
REQ-024 Beat 1: mem_addr = beat-0 address + XLEN/8 (wraps mod 2^XLEN); mem_be and mem_wdata carry the remaining high-order bytes at lane 0 upward.
REQ-025 Load assembly: beat-0 bytes from lane offset up, beat-1 bytes appended above; result truncated to size then sign- or zero-extended per req_unsigned.
REQ-026 RESP: rsp_valid=1, rsp_rdata/rsp_error held stable until rsp_ready; on rsp_ready -> IDLE; next request not accepted in the same cycle.
REQ-027 Minimum latency, aligned access, ready/rsp immediate: accept cycle N, mem_req_valid N+1, mem_rsp_valid N+2, rsp_valid N+3.
REQ-028 mem_rsp_valid outside WAIT0/WAIT1 is ignored.
REQ-029 Stores return rsp_rdata=0, rsp_error=0 after the final beat is acknowledged.

Reset
REQ-030 rst_n low: state=IDLE; req_ready=1 after release, rsp_valid=0, mem_req_valid=0, rsp_rdata=0, rsp_error=0, mem_be=0; captured registers cleared.
REQ-031 Reset mid-transaction aborts it immediately; no late response is produced for the aborted request; a pending bus beat is dropped.

Structure
REQ-032 Shared package holds the size enum (SIZE_B/H/W/D) and FSM state enum.
REQ-033 One sub-module, rv_lsu_align: combinational lane shifter/extender (store positioning, load assembly, sign extension), reused for both beats.

Verification
REQ-034 XLEN=32, LW addr 0x100, mem data 0xDEADBEEF -> one beat, be=1111, rsp_rdata 0xDEADBEEF, latency 3 cycles.
REQ-035 LB addr 0x103, data 0x80xxxxxx, signed -> 0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 SH addr 0x102, wdata 0x1234 -> mem_addr 0x100, be=1100, mem_wdata 0x12340000.
REQ-037 SPLIT_MISALIGNED=1, LW addr 0x103, beats 0x11xxxxxx then 0xxx332244 -> beats at 0x100 and 0x104, rsp_rdata 0x33224411.
REQ-038 SPLIT_MISALIGNED=0, SW addr 0x101 -> no mem_req_valid, rsp_error=1 one cycle after accept; XLEN=32 size 11 -> rsp_error=1.
REQ-039 mem_req_ready low 5 cycles, rsp_ready low 3 cycles, then rst_n pulse during WAIT0 -> bus fields stable while stalled, IDLE after reset, no rsp_valid.
